// File: rtl/mlp_pkg.sv
// Shared sizes and types for the mlp core and its stream input loader.
package mlp_pkg;

  localparam int DATA_SIZE        = 8;
  localparam int MAX_WEIGHTS_SIZE = 32;
  localparam int MAX_COL_ROW_BITS = 6;

  typedef enum logic [2:0] {
    FILL   = 3'd0,
    DRAIN  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } loader_state_t;

  // Effective frame length: zero still means one element, longer requests clamp to cap.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned cap);
    if (len == 32'd0) begin
      return 32'd1;
    end else if (len > cap) begin
      return cap;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/mlp_frame_buffer.sv
// Input vector register array: per-entry write, optional clear of all other entries on
// the same write, and a flat read-out bus (entry i at bits [i*DW +: DW]).
module mlp_frame_buffer
  import mlp_pkg::*;
#(
  parameter int DW    = DATA_SIZE,
  parameter int DEPTH = MAX_WEIGHTS_SIZE,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                clr_others,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  output logic [DW*DEPTH-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // Next value per entry: addressed entry takes the data, others clear on a frame start.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_addr == AW'(i))) begin
        mem_d[i] = wr_data;
      end else if (wr_en && clr_others) begin
        mem_d[i] = {DW{1'b0}};
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Entry storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Flatten the array onto the core-facing bus.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rd_data[i*DW +: DW] = mem_q[i];
    end
  end

endmodule

// File: rtl/mlp_input_loader.sv
// Stream-to-vector feeder for the mlp core: gathers one frame, launches the core and
// holds the core's result on a valid/ready port until it is taken.
module mlp_input_loader
  import mlp_pkg::*;
#(
  parameter int DATA_SIZE        = mlp_pkg::DATA_SIZE,
  parameter int MAX_WEIGHTS_SIZE = mlp_pkg::MAX_WEIGHTS_SIZE,
  parameter int MAX_COL_ROW_BITS = mlp_pkg::MAX_COL_ROW_BITS
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [DATA_SIZE-1:0]                  s_data,
  input  logic                                  s_last,
  input  logic [MAX_COL_ROW_BITS-1:0]           in_len,
  output logic [DATA_SIZE*MAX_WEIGHTS_SIZE-1:0] input_data,
  output logic                                  new_data,
  input  logic                                  output_ready,
  input  logic [DATA_SIZE-1:0]                  mlp_output,
  output logic                                  res_valid,
  output logic [DATA_SIZE-1:0]                  res_data,
  input  logic                                  res_ready,
  output logic                                  busy
);

  localparam int AW = (MAX_WEIGHTS_SIZE > 1) ? $clog2(MAX_WEIGHTS_SIZE) : 1;
  localparam int LW = MAX_COL_ROW_BITS;

  loader_state_t        state_q, state_d;
  logic [LW-1:0]        idx_q, idx_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 new_data_q, new_data_d;
  logic                 res_valid_q, res_valid_d;
  logic                 busy_q, busy_d;
  logic                 output_ready_q, output_ready_d;
  logic [DATA_SIZE-1:0] res_data_q, res_data_d;

  logic          beat_s;
  logic          first_beat_s;
  logic          buf_we_s;
  logic          buf_clr_s;
  logic [LW-1:0] len_cur_s;

  assign s_ready    = (state_q == FILL) || (state_q == DRAIN);
  assign new_data   = new_data_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign busy       = busy_q;

  assign beat_s       = s_valid && s_ready;
  assign first_beat_s = beat_s && (state_q == FILL) && (idx_q == {LW{1'b0}});

  // The first beat uses the freshly sampled length; later beats use the latched one.
  assign len_cur_s = first_beat_s
                   ? LW'(clamp_len(32'(in_len), 32'(MAX_WEIGHTS_SIZE)))
                   : len_q;

  // Frame sequencing, result capture and next values of the registered outputs.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    len_d          = len_q;
    res_data_d     = res_data_q;
    output_ready_d = output_ready;
    buf_we_s       = 1'b0;
    buf_clr_s      = 1'b0;
    case (state_q)
      FILL: begin
        if (beat_s) begin
          buf_we_s  = 1'b1;
          buf_clr_s = first_beat_s;
          len_d     = len_cur_s;
          idx_d     = idx_q + LW'(1);
          if (s_last) begin
            state_d = LAUNCH;
          end else if ((idx_q + LW'(1)) == len_cur_s) begin
            state_d = DRAIN;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      DRAIN: begin
        if (beat_s && s_last) begin
          state_d = LAUNCH;
        end else begin
          state_d = DRAIN;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Only a fresh rising edge counts; a level left high from earlier is ignored.
        if (output_ready && !output_ready_q) begin
          res_data_d = mlp_output;
          state_d    = RESULT;
        end else begin
          state_d = WAIT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d = FILL;
          idx_d   = {LW{1'b0}};
        end else begin
          state_d = RESULT;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = {LW{1'b0}};
      end
    endcase
    new_data_d  = (state_d == LAUNCH);
    res_valid_d = (state_d == RESULT);
    busy_d      = !((state_d == FILL) && (idx_d == {LW{1'b0}}));
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FILL;
      idx_q          <= {LW{1'b0}};
      len_q          <= {LW{1'b0}};
      new_data_q     <= 1'b0;
      res_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      output_ready_q <= 1'b0;
      res_data_q     <= {DATA_SIZE{1'b0}};
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      new_data_q     <= new_data_d;
      res_valid_q    <= res_valid_d;
      busy_q         <= busy_d;
      output_ready_q <= output_ready_d;
      res_data_q     <= res_data_d;
    end
  end

  mlp_frame_buffer #(
    .DW    (DATA_SIZE),
    .DEPTH (MAX_WEIGHTS_SIZE),
    .AW    (AW)
  ) u_frame_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (buf_we_s),
    .clr_others (buf_clr_s),
    .wr_addr    (idx_q[AW-1:0]),
    .wr_data    (s_data),
    .rd_data    (input_data)
  );

endmodule

// File: tb/tb_mlp_input_loader.sv
// Self-checking bench for mlp_input_loader: directed frame table, randomized frames
// against a length/truncation model, and an asynchronous reset in the middle of a wait.
module tb_mlp_input_loader;

  localparam int DW = 8;
  localparam int N  = 32;
  localparam int LW = 6;
  localparam int VW = DW * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic [LW-1:0] in_len;
  logic [VW-1:0] input_data;
  logic          new_data;
  logic          output_ready;
  logic [DW-1:0] mlp_output;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_ready;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]    bq [64];
  int            bn;
  logic [VW-1:0] exp_vec;

  typedef struct packed {
    logic [5:0]  len;
    logic [3:0]  n;
    logic [63:0] d;
    logic [63:0] exp;
    logic [7:0]  res;
    logic        carry;
    logic [2:0]  hold;
  } vec_t;

  vec_t tbl [6];

  mlp_input_loader #(
    .DATA_SIZE        (DW),
    .MAX_WEIGHTS_SIZE (N),
    .MAX_COL_ROW_BITS (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .in_len       (in_len),
    .input_data   (input_data),
    .new_data     (new_data),
    .output_ready (output_ready),
    .mlp_output   (mlp_output),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: only the first len_eff beats of a frame land in the vector, rest are zero.
  function automatic logic [VW-1:0] model_vec(input logic [5:0] len);
    logic [VW-1:0] v;
    int le;
    v  = '0;
    le = (len == 6'd0) ? 1 : ((int'(len) > N) ? N : int'(len));
    for (int k = 0; k < bn; k++) begin
      if (k < le) v[k*8 +: 8] = bq[k];
    end
    return v;
  endfunction

  // Streams bq[0..bn-1] with the final beat marked last; ends one cycle after launch.
  task automatic run_frame(input logic [5:0] len, input int gap_max);
    for (int k = 0; k < bn; k++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      s_valid = 1'b0;
      for (int j = 0; j < g; j++) begin
        in_len = 6'($urandom);
        step();
        chk1("new_data_gap", new_data, 1'b0);
      end
      chk1("s_ready_fill", s_ready, 1'b1);
      s_valid = 1'b1;
      s_data  = bq[k];
      s_last  = (k == bn - 1);
      in_len  = (k == 0) ? len : 6'($urandom);
      step();
      chk1("new_data_beat", new_data, (k == bn - 1));
      chk1("busy_frame", busy, 1'b1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chkv("input_data", input_data, exp_vec);
    step();
    chk1("new_data_one_cycle", new_data, 1'b0);
    chk1("s_ready_wait", s_ready, 1'b0);
  endtask

  // Result phase: optional stale-high output_ready, fresh edge capture, held result.
  task automatic run_result(input logic [7:0] val, input int hold, input logic carry);
    if (carry) begin
      for (int c = 0; c < 3; c++) begin
        mlp_output = 8'($urandom);
        s_valid    = 1'b1;
        s_data     = 8'($urandom);
        step();
        chk1("no_capture_level", res_valid, 1'b0);
        chk1("s_ready_wait_lvl", s_ready, 1'b0);
        chk1("busy_wait", busy, 1'b1);
      end
      s_valid      = 1'b0;
      output_ready = 1'b0;
      step();
      chk1("no_capture_fall", res_valid, 1'b0);
    end else begin
      step();
      chk1("no_capture_idle", res_valid, 1'b0);
    end
    output_ready = 1'b1;
    mlp_output   = val;
    step();
    chk1("res_valid_set", res_valid, 1'b1);
    chk8("res_data_capture", res_data, val);
    mlp_output   = ~val;
    output_ready = carry;
    s_valid      = 1'b1;
    s_data       = 8'($urandom);
    for (int h = 0; h < hold; h++) begin
      step();
      chk1("res_valid_hold", res_valid, 1'b1);
      chk8("res_data_hold", res_data, val);
      chk1("s_ready_result", s_ready, 1'b0);
      chkv("input_data_hold", input_data, exp_vec);
    end
    s_valid   = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready    = 1'b0;
    output_ready = 1'b0;
    chk1("res_valid_clear", res_valid, 1'b0);
    chk1("s_ready_refill", s_ready, 1'b1);
    chk1("busy_idle", busy, 1'b0);
    chkv("input_data_kept", input_data, exp_vec);
  endtask

  initial begin
    tbl[0] = '{len: 6'd2, n: 4'd2, d: 64'h0201,     exp: 64'h0201,     res: 8'h05, carry: 1'b0, hold: 3'd1};
    tbl[1] = '{len: 6'd4, n: 4'd4, d: 64'h01040002, exp: 64'h01040002, res: 8'hA3, carry: 1'b0, hold: 3'd2};
    tbl[2] = '{len: 6'd4, n: 4'd2, d: 64'h0807,     exp: 64'h0807,     res: 8'h11, carry: 1'b0, hold: 3'd0};
    tbl[3] = '{len: 6'd2, n: 4'd4, d: 64'h04030201, exp: 64'h0201,     res: 8'h22, carry: 1'b0, hold: 3'd1};
    tbl[4] = '{len: 6'd0, n: 4'd3, d: 64'h0B0A09,   exp: 64'h09,       res: 8'h33, carry: 1'b1, hold: 3'd5};
    tbl[5] = '{len: 6'd1, n: 4'd1, d: 64'h5A,       exp: 64'h5A,       res: 8'h44, carry: 1'b0, hold: 3'd1};

    rst_n        = 1'b1;
    s_valid      = 1'b0;
    s_data       = 8'h00;
    s_last       = 1'b0;
    in_len       = 6'd0;
    output_ready = 1'b0;
    mlp_output   = 8'h00;
    res_ready    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_new_data", new_data, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk8("rst_res_data", res_data, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chkv("rst_input_data", input_data, '0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk1("rst_s_ready", s_ready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      bn = int'(tbl[i].n);
      for (int k = 0; k < bn; k++) bq[k] = tbl[i].d[k*8 +: 8];
      exp_vec = {192'd0, tbl[i].exp};
      if (tbl[i].carry) output_ready = 1'b1;
      run_frame(tbl[i].len, 0);
      run_result(tbl[i].res, int'(tbl[i].hold), tbl[i].carry);
    end

    for (int f = 0; f < 40; f++) begin
      logic [5:0] len;
      logic       carry;
      len   = 6'($urandom);
      carry = 1'($urandom);
      bn    = int'($urandom_range(40, 1));
      for (int k = 0; k < bn; k++) bq[k] = 8'($urandom);
      exp_vec = model_vec(len);
      if (carry) output_ready = 1'b1;
      run_frame(len, 2);
      run_result(8'($urandom_range(255, 1)), int'($urandom_range(4, 0)), carry);
    end

    bn    = 3;
    bq[0] = 8'h11;
    bq[1] = 8'h22;
    bq[2] = 8'h33;
    exp_vec = model_vec(6'd3);
    run_frame(6'd3, 0);
    rst_n = 1'b0;
    #1;
    chk1("wait_rst_new_data", new_data, 1'b0);
    chk1("wait_rst_res_valid", res_valid, 1'b0);
    chk8("wait_rst_res_data", res_data, 8'h00);
    chk1("wait_rst_busy", busy, 1'b0);
    chkv("wait_rst_input_data", input_data, '0);
    step();
    rst_n = 1'b1;
    step();
    chk1("post_rst_s_ready", s_ready, 1'b1);
    chk1("post_rst_busy", busy, 1'b0);
    chkv("post_rst_input_data", input_data, '0);

    bn = 5;
    for (int k = 0; k < bn; k++) bq[k] = 8'($urandom);
    exp_vec = model_vec(6'd5);
    run_frame(6'd5, 1);
    run_result(8'h6C, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
